// File: rtl/atm_keypad_session.sv
// ATM customer-session front end: card insert, PIN entry with retry/lockout,
// operation menu, amount entry, inactivity timeout and request handshake.
module atm_keypad_session #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  card_acc,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        auth_done,
  input  logic        auth_ok,
  input  logic        req_ready,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        pin_valid,
  output logic [2:0]  operation,
  output logic [15:0] amount,
  output logic        req_valid,
  output logic        locked,
  output logic [2:0]  attempts_left,
  output logic [2:0]  state
);

  localparam int          TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  MAX_A  = 3'(MAX_ATTEMPTS);

  localparam logic [3:0] K_CLEAR  = 4'd10;
  localparam logic [3:0] K_ENTER  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PIN     = 3'd1,
    S_VERIFY  = 3'd2,
    S_MENU    = 3'd3,
    S_AMOUNT  = 3'd4,
    S_ISSUE   = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  state_t        r_state,     w_state_n;
  logic          r_card_d;
  logic [3:0]    r_acc,       w_acc_n;
  logic [15:0]   r_pin,       w_pin_n;
  logic [2:0]    r_cnt,       w_cnt_n;
  logic          r_pin_valid, w_pin_valid_n;
  logic [2:0]    r_op,        w_op_n;
  logic [15:0]   r_amt,       w_amt_n;
  logic          r_locked,    w_locked_n;
  logic [2:0]    r_att,       w_att_n;
  logic          r_new_pin,   w_new_pin_n;
  logic [TW-1:0] r_timer,     w_timer_n;

  logic        w_rise, w_fall, w_is_digit, w_timed, w_abort;
  logic [19:0] w_amt_calc;

  assign w_rise     = card_in & ~r_card_d;
  assign w_fall     = ~card_in & r_card_d;
  assign w_is_digit = key_valid && (key_code <= 4'd9);
  assign w_timed    = (r_state == S_PIN) || (r_state == S_MENU) || (r_state == S_AMOUNT);
  assign w_amt_calc = {4'd0, r_amt} * 20'd10 + {16'd0, key_code};

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_n     = r_state;
    w_acc_n       = r_acc;
    w_pin_n       = r_pin;
    w_cnt_n       = r_cnt;
    w_pin_valid_n = 1'b0;
    w_op_n        = r_op;
    w_amt_n       = r_amt;
    w_locked_n    = r_locked;
    w_att_n       = r_att;
    w_new_pin_n   = r_new_pin;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_rise && (card_acc <= 4'd9)) begin
          w_acc_n   = card_acc;
          w_pin_n   = '0;
          w_cnt_n   = '0;
          w_state_n = S_PIN;
        end
      end
      S_PIN: begin
        if (w_is_digit) begin
          if (r_cnt < 3'd4) begin
            w_pin_n = {r_pin[11:0], key_code};
            w_cnt_n = r_cnt + 3'd1;
          end
        end else if (key_valid && key_code == K_CLEAR) begin
          w_pin_n = '0;
          w_cnt_n = '0;
        end else if (key_valid && key_code == K_ENTER) begin
          if (r_cnt == 3'd4) begin
            if (r_new_pin) begin
              w_state_n = S_ISSUE;
            end else begin
              w_pin_valid_n = 1'b1;
              w_state_n     = S_VERIFY;
            end
          end
        end else if (key_valid && key_code == K_CANCEL) begin
          w_abort = 1'b1;
        end
      end
      S_VERIFY: begin
        if (auth_done) begin
          if (auth_ok) begin
            w_att_n   = MAX_A;
            w_state_n = S_MENU;
          end else if (r_att <= 3'd1) begin
            w_att_n    = '0;
            w_locked_n = 1'b1;
            w_state_n  = S_LOCKOUT;
          end else begin
            w_att_n   = r_att - 3'd1;
            w_pin_n   = '0;
            w_cnt_n   = '0;
            w_state_n = S_PIN;
          end
        end
      end
      S_MENU: begin
        if (w_is_digit) begin
          case (key_code)
            4'd1: begin
              w_op_n    = 3'd1;
              w_amt_n   = '0;
              w_state_n = S_ISSUE;
            end
            4'd2, 4'd3: begin
              w_op_n    = key_code[2:0];
              w_amt_n   = '0;
              w_state_n = S_AMOUNT;
            end
            4'd4: begin
              // Change PIN reuses PIN entry; the flag diverts ENTER to ISSUE.
              w_op_n      = 3'd4;
              w_pin_n     = '0;
              w_cnt_n     = '0;
              w_new_pin_n = 1'b1;
              w_state_n   = S_PIN;
            end
            4'd5:    w_abort = 1'b1;
            default: ;
          endcase
        end else if (key_valid && key_code == K_CANCEL) begin
          w_abort = 1'b1;
        end
      end
      S_AMOUNT: begin
        if (w_is_digit) begin
          w_amt_n = (w_amt_calc > 20'd9999) ? 16'd9999 : w_amt_calc[15:0];
        end else if (key_valid && key_code == K_CLEAR) begin
          w_amt_n = '0;
        end else if (key_valid && key_code == K_ENTER) begin
          if (r_amt != 16'd0) w_state_n = S_ISSUE;
        end else if (key_valid && key_code == K_CANCEL) begin
          w_abort = 1'b1;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          w_new_pin_n = 1'b0;
          w_state_n   = S_MENU;
        end
      end
      S_LOCKOUT: begin
        if (w_fall) begin
          w_locked_n = 1'b0;
          w_att_n    = MAX_A;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_timed && !key_valid && (r_timer == TLAST)) w_abort = 1'b1;
    if (w_fall && (r_state != S_LOCKOUT))            w_abort = 1'b1;

    // Card removal outranks every other event, including a same-cycle key or verdict.
    if (w_abort) begin
      w_pin_n       = '0;
      w_cnt_n       = '0;
      w_amt_n       = '0;
      w_op_n        = '0;
      w_att_n       = MAX_A;
      w_locked_n    = 1'b0;
      w_new_pin_n   = 1'b0;
      w_pin_valid_n = 1'b0;
      w_state_n     = S_IDLE;
    end

    w_timer_n = (w_timed && !key_valid && (w_state_n == r_state)) ? r_timer + TW'(1) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_card_d    <= 1'b0;
      r_acc       <= '0;
      r_pin       <= '0;
      r_cnt       <= '0;
      r_pin_valid <= 1'b0;
      r_op        <= '0;
      r_amt       <= '0;
      r_locked    <= 1'b0;
      r_att       <= MAX_A;
      r_new_pin   <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_card_d    <= card_in;
      r_acc       <= w_acc_n;
      r_pin       <= w_pin_n;
      r_cnt       <= w_cnt_n;
      r_pin_valid <= w_pin_valid_n;
      r_op        <= w_op_n;
      r_amt       <= w_amt_n;
      r_locked    <= w_locked_n;
      r_att       <= w_att_n;
      r_new_pin   <= w_new_pin_n;
      r_timer     <= w_timer_n;
    end
  end

  assign acc_num       = r_acc;
  assign pin           = r_pin;
  assign pin_valid     = r_pin_valid;
  assign operation     = r_op;
  assign amount        = r_amt;
  assign req_valid     = (r_state == S_ISSUE) && !w_fall;
  assign locked        = r_locked;
  assign attempts_left = r_att;
  assign state         = r_state;

endmodule

// File: tb/tb_atm_keypad_session.sv
// Directed and randomized bench for atm_keypad_session, scored against a
// rule-level session model held in plain integers.
module tb_atm_keypad_session;

  localparam int MAXA = 3;
  localparam int TOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        card_in = 1'b0;
  logic [3:0]  card_acc = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        auth_done = 1'b0;
  logic        auth_ok = 1'b0;
  logic        req_ready = 1'b0;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        pin_valid;
  logic [2:0]  operation;
  logic [15:0] amount;
  logic        req_valid;
  logic        locked;
  logic [2:0]  attempts_left;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  atm_keypad_session #(.MAX_ATTEMPTS(MAXA), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_acc(card_acc),
    .key_valid(key_valid), .key_code(key_code), .auth_done(auth_done),
    .auth_ok(auth_ok), .req_ready(req_ready), .acc_num(acc_num), .pin(pin),
    .pin_valid(pin_valid), .operation(operation), .amount(amount),
    .req_valid(req_valid), .locked(locked), .attempts_left(attempts_left),
    .state(state)
  );

  always #5 clk = ~clk;

  // Session model: phase numbers are the published display codes.
  int m_phase, m_acc, m_pin, m_digits, m_pv, m_op, m_amt, m_locked, m_att, m_newpin, m_quiet, m_card_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_acc = 0; m_pin = 0; m_digits = 0; m_pv = 0; m_op = 0;
    m_amt = 0; m_locked = 0; m_att = MAXA; m_newpin = 0; m_quiet = 0; m_card_prev = 0;
  endtask

  function automatic int exp_req_valid();
    return (m_phase == 5 && !(m_card_prev == 1 && card_in == 1'b0)) ? 1 : 0;
  endfunction

  task automatic model_update();
    int  k, start;
    bit  fall, rise, kv, abort, timed;
    if (rst) begin
      model_reset();
      return;
    end
    k     = int'(key_code);
    kv    = key_valid;
    fall  = (m_card_prev == 1) && !card_in;
    rise  = (m_card_prev == 0) && card_in;
    start = m_phase;
    timed = (start == 1 || start == 3 || start == 4);
    abort = 0;
    m_pv  = 0;
    if (fall && start != 6) abort = 1;
    else if (timed && !kv && m_quiet + 1 == TOUT) abort = 1;
    else begin
      case (start)
        0: if (rise && card_acc < 10) begin
             m_acc = int'(card_acc); m_pin = 0; m_digits = 0; m_phase = 1;
           end
        1: if (kv) begin
             if (k < 10) begin
               if (m_digits < 4) begin m_pin = (m_pin * 16 + k) % 65536; m_digits++; end
             end else if (k == 10) begin m_pin = 0; m_digits = 0; end
             else if (k == 11 && m_digits == 4) begin
               if (m_newpin != 0) m_phase = 5;
               else begin m_pv = 1; m_phase = 2; end
             end else if (k == 12) abort = 1;
           end
        2: if (auth_done) begin
             if (auth_ok) begin m_att = MAXA; m_phase = 3; end
             else begin
               m_att--;
               if (m_att == 0) begin m_locked = 1; m_phase = 6; end
               else begin m_pin = 0; m_digits = 0; m_phase = 1; end
             end
           end
        3: if (kv) begin
             if (k == 1) begin m_op = 1; m_amt = 0; m_phase = 5; end
             else if (k == 2 || k == 3) begin m_op = k; m_amt = 0; m_phase = 4; end
             else if (k == 4) begin m_op = 4; m_pin = 0; m_digits = 0; m_newpin = 1; m_phase = 1; end
             else if (k == 5 || k == 12) abort = 1;
           end
        4: if (kv) begin
             if (k < 10) m_amt = (m_amt * 10 + k > 9999) ? 9999 : m_amt * 10 + k;
             else if (k == 10) m_amt = 0;
             else if (k == 11 && m_amt > 0) m_phase = 5;
             else if (k == 12) abort = 1;
           end
        5: if (req_ready) begin m_newpin = 0; m_phase = 3; end
        6: if (fall) begin m_locked = 0; m_att = MAXA; m_phase = 0; end
        default: ;
      endcase
    end
    if (abort) begin
      m_pin = 0; m_digits = 0; m_amt = 0; m_op = 0; m_att = MAXA;
      m_locked = 0; m_newpin = 0; m_pv = 0; m_phase = 0;
    end
    if (timed && !kv && m_phase == start) m_quiet++;
    else m_quiet = 0;
    m_card_prev = card_in ? 1 : 0;
  endtask

  task automatic compare_all();
    check("state", 32'(state), m_phase);
    check("acc_num", 32'(acc_num), m_acc);
    check("pin", 32'(pin), m_pin);
    check("pin_valid", 32'(pin_valid), m_pv);
    check("operation", 32'(operation), m_op);
    check("amount", 32'(amount), m_amt);
    check("req_valid", 32'(req_valid), exp_req_valid());
    check("locked", 32'(locked), m_locked);
    check("attempts_left", 32'(attempts_left), m_att);
  endtask

  task automatic step();
    @(negedge clk);
    check("req_valid_pre_edge", 32'(req_valid), exp_req_valid());
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 4'(k);
    step();
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic enter_pin(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(11);
  endtask

  task automatic auth(input bit ok);
    auth_done = 1'b1;
    auth_ok   = ok;
    step();
    auth_done = 1'b0;
    auth_ok   = 1'b0;
  endtask

  task automatic insert(input int acc);
    card_acc = 4'(acc);
    card_in  = 1'b1;
    step();
  endtask

  task automatic remove();
    card_in = 1'b0;
    step();
  endtask

  task automatic issue_ack();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  initial begin
    // Reset from power-up without scoring the unknown pre-reset cycle.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check("reset_state", 32'(state), 0);
    check("reset_attempts", 32'(attempts_left), MAXA);
    check("reset_pin", 32'(pin), 0);
    check("reset_req_valid", 32'(req_valid), 0);
    check("reset_locked", 32'(locked), 0);

    // Card insert and PIN entry.
    insert(3);
    enter_pin(1, 2, 3, 4);
    check("insert_acc", 32'(acc_num), 3);
    check("insert_pin", 32'(pin), 32'h1234);
    check("insert_pin_valid", 32'(pin_valid), 1);
    check("insert_state", 32'(state), 2);
    step();
    check("pin_valid_one_cycle", 32'(pin_valid), 0);

    // Three wrong PINs lock the card.
    auth(1'b0);
    check("retry1_attempts", 32'(attempts_left), 2);
    check("retry1_state", 32'(state), 1);
    enter_pin(1, 2, 3, 4);
    auth(1'b0);
    check("retry2_attempts", 32'(attempts_left), 1);
    enter_pin(1, 2, 3, 4);
    auth(1'b0);
    check("lock_attempts", 32'(attempts_left), 0);
    check("lock_flag", 32'(locked), 1);
    check("lock_state", 32'(state), 6);
    press(5);
    press(12);
    check("lock_keys_ignored", 32'(state), 6);
    remove();
    check("unlock_state", 32'(state), 0);
    check("unlock_flag", 32'(locked), 0);
    check("unlock_attempts", 32'(attempts_left), MAXA);

    // Withdraw with backpressure.
    insert(7);
    enter_pin(4, 3, 2, 1);
    auth(1'b1);
    check("menu_state", 32'(state), 3);
    auth(1'b0);
    check("stray_auth_ignored", 32'(attempts_left), MAXA);
    press(2);
    check("withdraw_state", 32'(state), 4);
    press(1); press(5); press(0);
    check("withdraw_amount", 32'(amount), 150);
    press(11);
    check("withdraw_req_valid", 32'(req_valid), 1);
    check("withdraw_op", 32'(operation), 2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_req_valid", 32'(req_valid), 1);
      check("hold_amount", 32'(amount), 150);
      check("hold_acc", 32'(acc_num), 7);
      check("hold_pin", 32'(pin), 32'h4321);
    end
    issue_ack();
    check("after_ack_req_valid", 32'(req_valid), 0);
    check("after_ack_state", 32'(state), 3);

    // Amount saturation, clear and zero-amount ENTER.
    press(3);
    for (int i = 0; i < 5; i++) press(9);
    check("amount_saturate", 32'(amount), 9999);
    press(10);
    check("amount_clear", 32'(amount), 0);
    press(11);
    check("zero_enter_ignored", 32'(state), 4);
    press(7);
    press(11);
    check("deposit_amount", 32'(amount), 7);
    check("deposit_state", 32'(state), 5);
    issue_ack();

    // Timeout restarted by a late no-op key, then expiring.
    repeat (TOUT - 2) step();
    press(13);
    repeat (TOUT - 1) step();
    check("timeout_not_yet", 32'(state), 3);
    step();
    check("timeout_state", 32'(state), 0);
    check("timeout_pin", 32'(pin), 0);

    // Short ENTER and overlong PIN, then Change PIN.
    remove();
    insert(5);
    press(1); press(2); press(11);
    check("short_enter_ignored", 32'(state), 1);
    press(3); press(4); press(9);
    check("fifth_digit_ignored", 32'(pin), 32'h1234);
    press(11);
    step();
    auth(1'b1);
    press(4);
    check("newpin_state", 32'(state), 1);
    check("newpin_op", 32'(operation), 4);
    enter_pin(5, 6, 7, 8);
    check("newpin_req_valid", 32'(req_valid), 1);
    check("newpin_pin", 32'(pin), 32'h5678);
    check("newpin_no_strobe", 32'(pin_valid), 0);
    issue_ack();
    check("newpin_back_to_menu", 32'(state), 3);

    // Card pulled during AMOUNT.
    press(3);
    press(4);
    remove();
    check("pull_amount_state", 32'(state), 0);
    check("pull_amount_req_valid", 32'(req_valid), 0);
    check("pull_amount_amount", 32'(amount), 0);
    check("pull_amount_acc_kept", 32'(acc_num), 5);

    // Card pulled during ISSUE drops req_valid before the edge.
    insert(2);
    enter_pin(1, 1, 1, 1);
    auth(1'b1);
    press(1);
    check("balance_req_valid", 32'(req_valid), 1);
    card_in = 1'b0;
    #2;
    check("pull_issue_immediate", 32'(req_valid), 0);
    step();
    check("pull_issue_state", 32'(state), 0);

    // Reset during ISSUE.
    insert(2);
    enter_pin(2, 2, 2, 2);
    auth(1'b1);
    press(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_issue_req_valid", 32'(req_valid), 0);
    check("rst_issue_state", 32'(state), 0);
    check("rst_issue_acc", 32'(acc_num), 0);

    // Bad card number stays idle.
    remove();
    insert(12);
    check("bad_card_state", 32'(state), 0);
    remove();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) begin
        card_in  = ~card_in;
        card_acc = 4'($urandom_range(0, 10));
      end
      key_valid = ($urandom_range(0, 2) == 0);
      key_code  = 4'($urandom_range(0, 15));
      auth_done = ($urandom_range(0, 7) == 0);
      auth_ok   = 1'($urandom_range(0, 1));
      req_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
